// File: rtl/mem_write_buffer_if.sv
// Bundle of MEM-stage request/response and data-memory port signals for the store buffer.
// The master side is the pipeline plus data memory; the slave side is mem_write_buffer.
interface mem_write_buffer_if #(
    parameter int WORD_LEN = 32
);
    logic                memWriteReq;
    logic                memReadReq;
    logic [WORD_LEN-1:0] address;
    logic [WORD_LEN-1:0] dataIn;
    logic [WORD_LEN-1:0] loadData;
    logic                stall;
    logic                fwdHit;
    logic                empty;
    logic                dmWriteEn;
    logic                dmReadEn;
    logic [WORD_LEN-1:0] dmAddress;
    logic [WORD_LEN-1:0] dmDataIn;
    logic [WORD_LEN-1:0] dmDataOut;

    modport master (
        output memWriteReq, memReadReq, address, dataIn, dmDataOut,
        input  loadData, stall, fwdHit, empty, dmWriteEn, dmReadEn, dmAddress, dmDataIn
    );

    modport slave (
        input  memWriteReq, memReadReq, address, dataIn, dmDataOut,
        output loadData, stall, fwdHit, empty, dmWriteEn, dmReadEn, dmAddress, dmDataIn
    );
endinterface

// File: rtl/mem_write_buffer.sv
// Store buffer between the MEM stage and data memory: queues stores, drains one per free cycle.
// Define WRITE_BUFFER_FWD_EN to serve matching loads from the buffer instead of stalling them.
module mem_write_buffer #(
    parameter int DEPTH    = 4,
    parameter int PTR_W    = 2,
    parameter int WORD_LEN = 32
) (
    input logic              clk,
    input logic              rst,
    mem_write_buffer_if.slave bus
);
    logic [WORD_LEN-1:0] addr_mem [DEPTH];
    logic [WORD_LEN-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W:0]      count;

    logic                full;
    logic                is_empty;
    logic                drain;
    logic                enq;
    logic                load_block;
    logic                match_any;
    logic [PTR_W-1:0]    idx;
`ifdef WRITE_BUFFER_FWD_EN
    logic [WORD_LEN-1:0] match_data;
`endif

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign is_empty = (count == '0);

    // Walk valid entries oldest to youngest so the last hit is the youngest store.
    always_comb begin
        match_any = 1'b0;
        idx       = '0;
`ifdef WRITE_BUFFER_FWD_EN
        match_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (((PTR_W+1)'(i) < count) && (addr_mem[idx] == bus.address)) begin
                match_any = 1'b1;
`ifdef WRITE_BUFFER_FWD_EN
                match_data = data_mem[idx];
`endif
            end
        end
    end

`ifdef WRITE_BUFFER_FWD_EN
    assign load_block   = 1'b0;
    assign bus.fwdHit   = bus.memReadReq && match_any;
    assign bus.loadData = bus.fwdHit ? match_data : bus.dmDataOut;
`else
    // A load hitting a pending store waits while drains retire the matching entries.
    assign load_block   = bus.memReadReq && match_any;
    assign bus.fwdHit   = 1'b0;
    assign bus.loadData = bus.dmDataOut;
`endif

    assign drain         = !is_empty && (!bus.memReadReq || load_block);
    assign enq           = bus.memWriteReq && (!full || drain);
    assign bus.stall     = (bus.memWriteReq && !enq) || load_block;
    assign bus.empty     = is_empty;
    assign bus.dmWriteEn = drain;
    assign bus.dmReadEn  = bus.memReadReq && !drain;
    assign bus.dmAddress = drain ? addr_mem[rd_ptr] : bus.address;
    assign bus.dmDataIn  = drain ? data_mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq)
                wr_ptr <= wr_ptr + 1'b1;
            if (drain)
                rd_ptr <= rd_ptr + 1'b1;
            if (enq && !drain)
                count <= count + 1'b1;
            else if (!enq && drain)
                count <= count - 1'b1;
        end
    end

    // Entry storage is never reset; validity comes only from the pointers and count.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[wr_ptr] <= bus.address;
            data_mem[wr_ptr] <= bus.dataIn;
        end
    end
endmodule

// File: tb/tb_mem_write_buffer.sv
// Scoreboard bench for mem_write_buffer: a queue-based store model predicts every cycle,
// a negedge monitor compares; build with or without WRITE_BUFFER_FWD_EN to match the RTL.
module tb_mem_write_buffer;
    localparam int DEPTH = 4;

    typedef struct {
        logic        stall;
        logic        fwdHit;
        logic        empty;
        logic        dmWriteEn;
        logic        dmReadEn;
        logic [31:0] dmAddress;
        logic [31:0] dmDataIn;
        logic [31:0] loadData;
        logic        chkLoad;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    exp_t        exp_q[$];
    ent_t        pend[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] dut_mem[logic [31:0]];

    mem_write_buffer_if #(.WORD_LEN(32)) bus ();

    mem_write_buffer #(.DEPTH(DEPTH), .PTR_W(2), .WORD_LEN(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] initWord(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] refRead(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : initWord(a);
    endfunction

    function automatic logic [31:0] dutRead(input logic [31:0] a);
        return dut_mem.exists(a) ? dut_mem[a] : initWord(a);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Data memory written by the DUT's port, as the real memory would be.
    always @(posedge clk) begin
        if (!rst && bus.dmWriteEn)
            dut_mem[bus.dmAddress] = bus.dmDataIn;
    end

    always @(posedge clk) begin
        assert (!(bus.memReadReq && bus.memWriteReq))
            else $error("[TB] illegal simultaneous load and store");
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("stall", 32'(bus.stall), 32'(e.stall));
            checkOutput("fwdHit", 32'(bus.fwdHit), 32'(e.fwdHit));
            checkOutput("empty", 32'(bus.empty), 32'(e.empty));
            checkOutput("dmWriteEn", 32'(bus.dmWriteEn), 32'(e.dmWriteEn));
            checkOutput("dmReadEn", 32'(bus.dmReadEn), 32'(e.dmReadEn));
            checkOutput("dmAddress", bus.dmAddress, e.dmAddress);
            checkOutput("dmDataIn", bus.dmDataIn, e.dmDataIn);
            if (e.chkLoad)
                checkOutput("loadData", bus.loadData, e.loadData);
        end
    end

    // One pipeline cycle: predict from the store queue, push the expectation, advance the model.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr,
                                 input logic [31:0] data, output logic stalled);
        exp_t        e;
        logic        found;
        logic [31:0] fdata;
        logic        blk;
        logic        hit;
        logic        drn;
        logic        enq;
        found = 1'b0;
        fdata = '0;
        foreach (pend[i]) begin
            if (pend[i].addr == addr) begin
                found = 1'b1;
                fdata = pend[i].data;
            end
        end
`ifdef WRITE_BUFFER_FWD_EN
        blk = 1'b0;
        hit = rd && found;
`else
        blk = rd && found;
        hit = 1'b0;
`endif
        drn = (pend.size() > 0) && (!rd || blk);
        enq = wr && ((pend.size() < DEPTH) || drn);
        e.stall     = (wr && !enq) || blk;
        e.fwdHit    = hit;
        e.empty     = (pend.size() == 0);
        e.dmWriteEn = drn;
        e.dmReadEn  = rd && !drn;
        e.dmAddress = drn ? pend[0].addr : addr;
        e.dmDataIn  = drn ? pend[0].data : 32'h0;
        e.loadData  = hit ? fdata : refRead(addr);
        e.chkLoad   = rd && !blk;
        exp_q.push_back(e);
        if (drn) begin
            ref_mem[pend[0].addr] = pend[0].data;
            void'(pend.pop_front());
        end
        if (enq)
            pend.push_back('{addr: addr, data: data});
        stalled = e.stall;
        bus.memWriteReq = wr;
        bus.memReadReq  = rd;
        bus.address     = addr;
        bus.dataIn      = data;
        #1;
        bus.dmDataOut = dutRead(bus.dmAddress);
        @(posedge clk);
        #1;
    endtask

    // A stalled MEM stage simply re-presents the same operation.
    task automatic doOp(input logic wr, input logic rd, input logic [31:0] addr, input logic [31:0] data);
        logic st;
        for (int n = 0; n < 20; n++) begin
            applyStimulus(wr, rd, addr, data, st);
            if (!st)
                return;
        end
        checks++;
        errors++;
        $display("[TB] FAIL stall_bound: operation at 0x%08h still stalled after 20 cycles", addr);
    endtask

    task automatic randomOps(input int n);
        for (int k = 0; k < n; k++) begin
            int          sel;
            logic [31:0] a;
            sel = int'($urandom_range(0, 9));
            a   = 32'h400 + 32'(4 * $urandom_range(0, 5));
            if (sel < 4)
                doOp(1'b1, 1'b0, a, $urandom);
            else if (sel < 8)
                doOp(1'b0, 1'b1, a, 32'h0);
            else
                doOp(1'b0, 1'b0, a, 32'h0);
        end
    endtask

    initial begin
        logic st;
        bus.memWriteReq = 1'b0;
        bus.memReadReq  = 1'b0;
        bus.address     = 32'h0;
        bus.dataIn      = 32'h0;
        bus.dmDataOut   = 32'h0;
        #13;
        checkOutput("reset_empty", 32'(bus.empty), 32'h1);
        checkOutput("reset_dmWriteEn", 32'(bus.dmWriteEn), 32'h0);
        checkOutput("reset_stall", 32'(bus.stall), 32'h0);
        checkOutput("reset_fwdHit", 32'(bus.fwdHit), 32'h0);
        #4 rst = 1'b0;
        @(posedge clk);
        #1;

        doOp(1'b1, 1'b0, 32'h400, 32'h11);
        doOp(1'b1, 1'b0, 32'h404, 32'h22);
        doOp(1'b0, 1'b0, 32'h0, 32'h0);
        doOp(1'b0, 1'b0, 32'h0, 32'h0);
        doOp(1'b0, 1'b1, 32'h400, 32'h0);
        doOp(1'b0, 1'b1, 32'h404, 32'h0);

        doOp(1'b1, 1'b0, 32'h408, 32'hAA);
        doOp(1'b1, 1'b0, 32'h408, 32'hBB);
        doOp(1'b0, 1'b1, 32'h408, 32'h0);
        doOp(1'b0, 1'b1, 32'h408, 32'h0);

        doOp(1'b1, 1'b0, 32'h40C, 32'h33);
        doOp(1'b0, 1'b1, 32'h500, 32'h0);
        doOp(1'b0, 1'b1, 32'h504, 32'h0);
        doOp(1'b0, 1'b0, 32'h0, 32'h0);

        randomOps(300);

        // Reset mid-cycle with a store pending: it must be dropped and the port go idle at once.
        applyStimulus(1'b1, 1'b0, 32'h600, 32'h77, st);
        @(negedge clk);
        bus.memWriteReq = 1'b0;
        bus.memReadReq  = 1'b1;
        bus.address     = 32'h604;
        #1;
        checkOutput("pre_reset_empty", 32'(bus.empty), 32'h0);
        rst = 1'b1;
        #1;
        checkOutput("async_empty", 32'(bus.empty), 32'h1);
        checkOutput("async_dmWriteEn", 32'(bus.dmWriteEn), 32'h0);
        checkOutput("async_dmAddress", bus.dmAddress, 32'h604);
        pend.delete();
        bus.memReadReq = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        doOp(1'b0, 1'b0, 32'h0, 32'h0);
        doOp(1'b0, 1'b1, 32'h600, 32'h0);

        randomOps(100);

        bus.memWriteReq = 1'b0;
        bus.memReadReq  = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
